// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the RV32I multicycle main control: FSM states, opcodes,
// alu_op codes and datapath mux selects.
package multicycle_main_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR     = 4'd10,
    S_JUMP     = 4'd11,
    S_LUI      = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multicycle_main_control.sv
// Main sequencing FSM of the RV32I multicycle core: decodes the IR opcode into
// per-cycle datapath strobes/selects, runs the memory req/ready handshake, counts retirements.
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic        illegal,
  output logic        instr_done,
  output logic [31:0] instret,
  output logic [3:0]  state_o
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instret;

  logic w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_reg_write;
  logic w_illegal, w_instr_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (instr_done) r_instret <= r_instret + 32'd1;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    adr_src      = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALU_ADD;
    result_src   = RES_ALUOUT;
    w_illegal    = 1'b0;
    w_instr_done = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // Speculative OldPC+imm lands in ALUOut for branch/JAL/AUIPC.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXEC_R;
          OP_ITYPE:          w_next = S_EXEC_I;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JUMP;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_ALUWB;
          OP_FENCE, OP_SYSTEM: begin
            w_next       = S_FETCH;
            w_instr_done = 1'b1;
          end
          default: begin
            w_illegal = 1'b1;
            w_next    = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_next    = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src   = RES_MEMDATA;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req    = 1'b1;
        w_mem_we     = 1'b1;
        adr_src      = 1'b1;
        w_instr_done = mem_ready;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_RTYPE;
        w_next    = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ITYPE;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        result_src   = RES_ALUOUT;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALU_SUB;
        result_src   = RES_ALUOUT;
        w_pc_write   = branch_taken;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_next    = S_JUMP;
      end
      S_JUMP: begin
        // PC takes the target from ALUOut while the ALU forms the link value.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        w_next    = S_ALUWB;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // Reset kills every strobe immediately so an aborted access never completes.
  assign mem_req    = rst_n & w_mem_req;
  assign mem_we     = rst_n & w_mem_we;
  assign ir_write   = rst_n & w_ir_write;
  assign pc_write   = rst_n & w_pc_write;
  assign reg_write  = rst_n & w_reg_write;
  assign illegal    = rst_n & w_illegal;
  assign instr_done = rst_n & w_instr_done;

  assign instret = r_instret;
  assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench: per-cycle expected outputs queued at drive time, compared at the
// falling edge; a second instance exercises the halt-on-illegal variant.
module tb_multicycle_main_control;

  logic        clk = 1'b0;
  logic        rst_n, branch_taken, mem_ready;
  logic [6:0]  opcode;

  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal, instr_done;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [31:0] instret;
  logic [3:0]  state_o;

  logic        h_mem_req, h_mem_we, h_adr_src, h_ir_write, h_pc_write, h_reg_write;
  logic        h_illegal, h_instr_done;
  logic [1:0]  h_alu_src_a, h_alu_src_b, h_alu_op, h_result_src;
  logic [31:0] h_instret;
  logic [3:0]  h_state_o;

  always #5 clk = ~clk;

  multicycle_main_control #(.HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .illegal(illegal), .instr_done(instr_done),
    .instret(instret), .state_o(state_o)
  );

  multicycle_main_control #(.HALT_ON_ILLEGAL(1'b1)) dut_halt (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(h_mem_req), .mem_we(h_mem_we), .adr_src(h_adr_src),
    .ir_write(h_ir_write), .pc_write(h_pc_write), .reg_write(h_reg_write),
    .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .alu_op(h_alu_op),
    .result_src(h_result_src), .illegal(h_illegal), .instr_done(h_instr_done),
    .instret(h_instret), .state_o(h_state_o)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic        req, we, adr, irw, pcw, rgw;
    logic [1:0]  a, b, op, rs;
    logic        ill, done;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          step  = 0;
  string       tname = "rst";
  logic [31:0] exp_cnt;

  // Expected outputs for a given state, written straight from the state table.
  function automatic exp_t model(input logic [3:0] st, input logic [6:0] opc,
                                 input logic rdy, input logic br, input logic rst,
                                 input logic [31:0] cnt);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.cnt = cnt;
    case (st)
      4'd0:  begin e.req = 1; e.b = 2'b10; e.rs = 2'b10; e.irw = rdy; e.pcw = rdy; end
      4'd1:  begin
        e.a = 2'b01; e.b = 2'b01;
        if (opc == 7'b0001111 || opc == 7'b1110011) e.done = 1;
        else if (!(opc inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111})) e.ill = 1;
      end
      4'd2:  begin e.a = 2'b10; e.b = 2'b01; end
      4'd3:  begin e.req = 1; e.adr = 1; end
      4'd4:  begin e.rs = 2'b01; e.rgw = 1; e.done = 1; end
      4'd5:  begin e.req = 1; e.we = 1; e.adr = 1; e.done = rdy; end
      4'd6:  begin e.a = 2'b10; e.b = 2'b00; e.op = 2'b10; end
      4'd7:  begin e.a = 2'b10; e.b = 2'b01; e.op = 2'b11; end
      4'd8:  begin e.rgw = 1; e.done = 1; end
      4'd9:  begin e.a = 2'b10; e.op = 2'b01; e.pcw = br; e.done = 1; end
      4'd10: begin e.a = 2'b10; e.b = 2'b01; end
      4'd11: begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1; end
      4'd12: begin e.a = 2'b11; e.b = 2'b01; end
      default: ;
    endcase
    if (!rst) begin
      e.req = 0; e.we = 0; e.irw = 0; e.pcw = 0; e.rgw = 0; e.ill = 0; e.done = 0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare mid-cycle.
  task automatic cyc(input logic [3:0] st, input logic rdy = 1'b1,
                     input logic br = 1'b0, input logic rst = 1'b1);
    exp_t e, got;
    rst_n = rst; mem_ready = rdy; branch_taken = br;
    q.push_back(model(st, opcode, rdy, br, rst, exp_cnt));
    @(negedge clk);
    e   = q.pop_front();
    got = {state_o, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, illegal, instr_done, instret};
    chk($sformatf("%s.c%0d", tname, step), 64'(got), 64'(e));
    step++;
    if (e.done) exp_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; opcode = '0; mem_ready = 1'b0; branch_taken = 1'b0; exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state",   64'(state_o),   64'(0));
    chk("rst.instret", 64'(instret),   64'(0));
    chk("rst.mem_req", 64'(mem_req),   64'(0));
    chk("rst.h_state", 64'(h_state_o), 64'(0));

    tname = "add"; opcode = 7'b0110011;
    cyc(0); cyc(1); cyc(6); cyc(8);
    chk("add.instret", 64'(instret), 64'(1));

    tname = "lw"; opcode = 7'b0000011;
    cyc(0); cyc(1); cyc(2); cyc(3, 0); cyc(3, 0); cyc(3, 0); cyc(3, 1); cyc(4);
    chk("lw.instret", 64'(instret), 64'(2));

    tname = "beq"; opcode = 7'b1100011;
    cyc(0); cyc(1); cyc(9, 1, 1);
    cyc(0); cyc(1); cyc(9, 1, 0);
    chk("beq.instret", 64'(instret), 64'(4));

    tname = "jalr"; opcode = 7'b1100111;
    cyc(0); cyc(1); cyc(10); cyc(11); cyc(8);
    chk("jalr.instret", 64'(instret), 64'(5));

    tname = "sw"; opcode = 7'b0100011;
    cyc(0); cyc(1); cyc(2); cyc(5);
    tname = "lui"; opcode = 7'b0110111;
    cyc(0); cyc(1); cyc(12); cyc(8);
    tname = "auipc"; opcode = 7'b0010111;
    cyc(0); cyc(1); cyc(8);
    tname = "jal"; opcode = 7'b1101111;
    cyc(0); cyc(1); cyc(11); cyc(8);
    tname = "addi"; opcode = 7'b0010011;
    cyc(0, 0); cyc(0, 0); cyc(0, 1); cyc(1); cyc(7); cyc(8);
    tname = "fence"; opcode = 7'b0001111;
    cyc(0); cyc(1);
    chk("mix.instret", 64'(instret), 64'(11));

    tname = "illegal"; opcode = 7'b1111111;
    cyc(0); cyc(1);
    chk("illegal.h_state", 64'(h_state_o), 64'(13));
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0);
      chk($sformatf("halt.state%0d", i),   64'(h_state_o), 64'(13));
      chk($sformatf("halt.mem_req%0d", i), 64'(h_mem_req), 64'(0));
    end
    chk("illegal.instret",   64'(instret),   64'(11));
    chk("illegal.h_instret", 64'(h_instret), 64'(11));

    tname = "swrst"; opcode = 7'b0100011;
    cyc(0); cyc(1); cyc(2); cyc(5, 0); cyc(5, 0);
    cyc(5, 0, 0, 0);
    exp_cnt = '0;
    chk("swrst.state",     64'(state_o),   64'(0));
    chk("swrst.instret",   64'(instret),   64'(0));
    chk("swrst.h_state",   64'(h_state_o), 64'(0));
    chk("swrst.h_instret", 64'(h_instret), 64'(0));

    tname = "post"; opcode = 7'b0010111;
    cyc(0); cyc(1); cyc(8);
    chk("post.instret", 64'(instret), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
